// File: rtl/prod_accumulator.sv
// Frame accumulator: sums frame_len unsigned 64-bit products into an ACC_W-bit result.
// Optional build macro PROD_ACC_SAT_EN clamps an overflowing sum instead of wrapping it.
module prod_accumulator #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             prod_ready_s;
  logic             prod_xfer_s;
  logic             res_xfer_s;
  logic [ACC_W-1:0] prod_ext_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [ACC_W:0]   step_s;

  // One accumulate step: returns {sticky overflow, new accumulator value}.
  function automatic logic [ACC_W:0] acc_step(
    input logic [ACC_W-1:0] acc,
    input logic [ACC_W-1:0] addend,
    input logic             ovf_in
  );
    logic [ACC_W:0]   sum;
    logic             ovf_out;
    logic [ACC_W-1:0] acc_new;
    sum     = {1'b0, acc} + {1'b0, addend};
    ovf_out = ovf_in | sum[ACC_W];
`ifdef PROD_ACC_SAT_EN
    if (ovf_out) begin
      acc_new = {ACC_W{1'b1}};
    end else begin
      acc_new = sum[ACC_W-1:0];
    end
`else
    acc_new = sum[ACC_W-1:0];
`endif
    return {ovf_out, acc_new};
  endfunction

  // clear vetoes both handshakes so an aborted cycle neither loads nor releases data
  assign prod_xfer_s = prod_valid & prod_ready_s & ~clear;
  assign res_xfer_s  = (state_q == ST_HOLD) & acc_ready & ~clear;
  assign prod_ext_s  = ACC_W'(prod);
  assign cnt_inc_s   = cnt_q + CNT_W'(1);
  assign step_s      = acc_step(acc_q, prod_ext_s, ovf_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (prod_xfer_s) begin
            state_d = (frame_len <= CNT_W'(1)) ? ST_HOLD : ST_ACC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACC: begin
          if (prod_xfer_s && (cnt_inc_s == len_q)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_HOLD: begin
          if (res_xfer_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prod_ready_s = (state_q != ST_HOLD) & ~rst;
    prod_ready   = prod_ready_s;
    acc_valid    = (state_q == ST_HOLD);
    busy         = (state_q != ST_IDLE);
    acc_out      = acc_q;
    acc_ovf      = ovf_q;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (prod_xfer_s && (state_q == ST_IDLE)) begin
      len_d = frame_len;
      acc_d = prod_ext_s;
      cnt_d = CNT_W'(1);
      ovf_d = 1'b0;
    end else if (prod_xfer_s && (state_q == ST_ACC)) begin
      acc_d = step_s[ACC_W-1:0];
      ovf_d = step_s[ACC_W];
      cnt_d = cnt_inc_s;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
